// File: rtl/sa3_job_scheduler.sv
// sa3_job_scheduler
// Round-robin arbiter and sequencer sharing one 3x3 systolic convolution
// array between two requesters. Each job grants a requester, latches its
// tile and filter, clears the array, runs it until done or a watchdog
// expires, then hands the 2x2 result back through a valid/ready handshake.

module sa3_job_scheduler #(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 6
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0,
    input  logic [127:0] a0,
    input  logic [71:0]  b0,
    output logic         gnt0,

    input  logic         req1,
    input  logic [127:0] a1,
    input  logic [71:0]  b1,
    output logic         gnt1,

    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [31:0]  res_c,
    output logic         res_err,
    output logic         busy,

    output logic         sa_clr,
    output logic         sa_active,
    output logic [127:0] sa_a,
    output logic [71:0]  sa_b,
    input  logic         sa_done,
    input  logic [31:0]  sa_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic               r_rr;
    logic               r_id;
    logic [CNT_W-1:0]   r_cnt;
    logic [127:0]       r_saA;
    logic [71:0]        r_saB;
    logic               r_saClr;
    logic               r_saActive;
    logic               r_resValid;
    logic [31:0]        r_resC;
    logic               r_resErr;
    logic               r_busy;

    logic               w_gnt0;
    logic               w_gnt1;

    // Grant only in IDLE; a lone requester wins, a tie goes to the rr pointer.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state == S_IDLE) begin
            w_gnt0 = req0 && (!req1 || !r_rr);
            w_gnt1 = req1 && (!req0 ||  r_rr);
        end
    end

    // Job sequencer: grant/latch, one-cycle clear, run with watchdog, respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_id       <= 1'b0;
            r_cnt      <= '0;
            r_saA      <= '0;
            r_saB      <= '0;
            r_saClr    <= 1'b0;
            r_saActive <= 1'b0;
            r_resValid <= 1'b0;
            r_resC     <= '0;
            r_resErr   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_saA   <= w_gnt1 ? a1 : a0;
                        r_saB   <= w_gnt1 ? b1 : b0;
                        r_id    <= w_gnt1;
                        r_saClr <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    r_saClr    <= 1'b0;
                    r_saActive <= 1'b1;
                    r_cnt      <= '0;
                    r_state    <= S_RUN;
                end

                S_RUN: begin
                    if (sa_done) begin
                        r_resC     <= sa_c;
                        r_resErr   <= 1'b0;
                        r_saActive <= 1'b0;
                        r_resValid <= 1'b1;
                        r_state    <= S_RESP;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_resC     <= '0;
                        r_resErr   <= 1'b1;
                        r_saActive <= 1'b0;
                        r_resValid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + LP_CNT_ONE;
                    end
                end

                S_RESP: begin
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        r_rr       <= ~r_id;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;
    assign res_valid = r_resValid;
    assign res_id    = r_id;
    assign res_c     = r_resC;
    assign res_err   = r_resErr;
    assign busy      = r_busy;
    assign sa_clr    = r_saClr;
    assign sa_active = r_saActive;
    assign sa_a      = r_saA;
    assign sa_b      = r_saB;

endmodule

// File: tb/tb_sa3_job_scheduler.sv
// tb_sa3_job_scheduler
// Directed bench for the job scheduler: a table of jobs with hand-computed
// grant order, run length and response, plus a hand-written sequence for
// operand latching and asynchronous reset in the middle of a run.

module tb_sa3_job_scheduler;

    localparam int TIMEOUT = 32;
    localparam int CNT_W   = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [127:0] a0, a1;
    logic [71:0]  b0, b1;
    logic         gnt0, gnt1;
    logic         res_valid, res_ready, res_id, res_err, busy;
    logic [31:0]  res_c;
    logic         sa_clr, sa_active, sa_done;
    logic [127:0] sa_a;
    logic [71:0]  sa_b;
    logic [31:0]  sa_c;

    logic [127:0] aPat0, aPat1;
    logic [71:0]  bPat0, bPat1;

    int           stubN;
    logic         stubEn;
    logic [31:0]  stubC;
    int           stubCnt;

    int           vecCount  = 0;
    int           missCount = 0;

    typedef struct {
        logic        req0;
        logic        req1;
        int          stubN;
        logic        stubEn;
        logic [31:0] saC;
        int          readyDelay;
        logic        expId;
        logic [31:0] expC;
        logic        expErr;
        int          expRun;
    } jobVec_t;

    jobVec_t jobs[10];

    sa3_job_scheduler #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .gnt0      (gnt0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .gnt1      (gnt1),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_c     (res_c),
        .res_err   (res_err),
        .busy      (busy),
        .sa_clr    (sa_clr),
        .sa_active (sa_active),
        .sa_a      (sa_a),
        .sa_b      (sa_b),
        .sa_done   (sa_done),
        .sa_c      (sa_c)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Stub array: counts active cycles since the last clear and fires done on the Nth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            stubCnt <= 0;
        else if (sa_clr)    stubCnt <= 0;
        else if (sa_active) stubCnt <= stubCnt + 1;
    end

    assign sa_done = stubEn && sa_active && (stubCnt == stubN - 1);
    assign sa_c    = stubC;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one table job: grant, clear pulse, run length, response, backpressure, accept.
    task automatic applyStimulus(input jobVec_t v, input int idx);
        int   waitCnt;
        int   runCnt;
        logic gotGrant;
        logic quiet;
        logic stable;

        @(posedge clk); #1;
        res_ready = 1'b0;
        req0      = v.req0;
        req1      = v.req1;
        stubN     = v.stubN;
        stubEn    = v.stubEn;
        stubC     = v.saC;
        @(negedge clk);
        checkOutput($sformatf("job%0d idleValid", idx), res_valid, 1'b0);

        gotGrant = 1'b0;
        waitCnt  = 0;
        while (!gotGrant && waitCnt < 8) begin
            if (gnt0 || gnt1) begin
                gotGrant = 1'b1;
            end else begin
                @(posedge clk); #1;
                @(negedge clk);
                waitCnt++;
            end
        end
        checkOutput($sformatf("job%0d grantSeen", idx), gotGrant, 1'b1);
        if (!gotGrant) return;
        checkOutput($sformatf("job%0d gntExclusive", idx), gnt0 & gnt1, 1'b0);
        checkOutput($sformatf("job%0d grantId", idx), gnt1, v.expId);

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput($sformatf("job%0d clrPulse", idx),
                    {sa_clr, sa_active, gnt0, gnt1, busy}, 5'b10001);
        checkOutput($sformatf("job%0d saA", idx), sa_a, v.expId ? aPat1 : aPat0);
        checkOutput($sformatf("job%0d saB", idx), sa_b, v.expId ? bPat1 : bPat0);

        runCnt = 0;
        quiet  = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        while (sa_active && runCnt < 100) begin
            runCnt++;
            if (sa_clr || gnt0 || gnt1 || res_valid) quiet = 1'b0;
            @(posedge clk); #1;
            @(negedge clk);
        end
        checkOutput($sformatf("job%0d runQuiet", idx), quiet, 1'b1);
        checkOutput($sformatf("job%0d runCycles", idx), runCnt, v.expRun);
        checkOutput($sformatf("job%0d respFlags", idx),
                    {res_valid, res_id, res_err, sa_active, busy},
                    {1'b1, v.expId, v.expErr, 1'b0, 1'b1});
        checkOutput($sformatf("job%0d respC", idx), res_c, v.expC);

        stable = 1'b1;
        for (int d = 0; d < v.readyDelay; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (!res_valid || res_c !== v.expC || res_id !== v.expId ||
                gnt0 || gnt1 || sa_active)
                stable = 1'b0;
        end
        if (v.readyDelay > 0)
            checkOutput($sformatf("job%0d holdStable", idx), stable, 1'b1);

        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("job%0d acceptCycle", idx),
                    {res_valid, res_id, gnt0, gnt1}, {1'b1, v.expId, 2'b00});
    endtask

    // Global time limit so the bench always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset checks, job table, then mid-run reset sequence.
    initial begin
        int n;

        for (int k = 0; k < 16; k++) begin
            aPat0[8*k +: 8] = 8'(k + 1);
            aPat1[8*k +: 8] = 8'(8'h80 + k + 1);
        end
        for (int k = 0; k < 9; k++) begin
            bPat0[8*k +: 8] = 8'(k + 1);
            bPat1[8*k +: 8] = 8'(8'hA0 + k + 1);
        end

        //           req0  req1  N   en    saC            dly id    expC           err   run
        jobs[0] = '{1'b1, 1'b1, 17, 1'b1, 32'h11223344, 0,  1'b0, 32'h11223344, 1'b0, 17};
        jobs[1] = '{1'b1, 1'b1, 17, 1'b1, 32'h55667788, 0,  1'b1, 32'h55667788, 1'b0, 17};
        jobs[2] = '{1'b1, 1'b1, 5,  1'b1, 32'h0A0B0C0D, 0,  1'b0, 32'h0A0B0C0D, 1'b0, 5};
        jobs[3] = '{1'b1, 1'b1, 17, 1'b1, 32'hDEADBEEF, 2,  1'b1, 32'hDEADBEEF, 1'b0, 17};
        jobs[4] = '{1'b1, 1'b0, 17, 1'b1, 32'h04030201, 0,  1'b0, 32'h04030201, 1'b0, 17};
        jobs[5] = '{1'b0, 1'b1, 17, 1'b0, 32'hFFFFFFFF, 0,  1'b1, 32'h00000000, 1'b1, 32};
        jobs[6] = '{1'b0, 1'b1, 17, 1'b1, 32'hCAFEF00D, 0,  1'b1, 32'hCAFEF00D, 1'b0, 17};
        jobs[7] = '{1'b1, 1'b0, 1,  1'b1, 32'h00000001, 0,  1'b0, 32'h00000001, 1'b0, 1};
        jobs[8] = '{1'b0, 1'b1, 32, 1'b1, 32'h80402010, 0,  1'b1, 32'h80402010, 1'b0, 32};
        jobs[9] = '{1'b1, 1'b0, 17, 1'b1, 32'h12345678, 10, 1'b0, 32'h12345678, 1'b0, 17};

        rst       = 1'b1;
        req0      = 1'b0;
        req1      = 1'b0;
        res_ready = 1'b0;
        a0        = aPat0;
        a1        = aPat1;
        b0        = bPat0;
        b1        = bPat1;
        stubN     = 17;
        stubEn    = 1'b1;
        stubC     = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstFlags",
                    {gnt0, gnt1, res_valid, res_id, res_err, busy, sa_clr, sa_active}, 8'h00);
        checkOutput("rstResC", res_c, 32'h0);
        checkOutput("rstSaA", sa_a, 128'h0);
        checkOutput("rstSaB", sa_b, 72'h0);

        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) applyStimulus(jobs[i], i);

        // Operand latch and asynchronous reset during RUN.
        @(posedge clk); #1;
        res_ready = 1'b0;
        req0      = 1'b1;
        req1      = 1'b0;
        stubEn    = 1'b1;
        stubN     = 17;
        stubC     = 32'h0BADF00D;
        @(negedge clk);
        checkOutput("hand gnt0", {gnt0, gnt1}, 2'b10);

        @(posedge clk); #1;
        req0 = 1'b0;
        a0   = ~aPat0;
        @(negedge clk);
        checkOutput("hand clr", {sa_clr, sa_active}, 2'b10);

        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
        end
        checkOutput("hand run5 active", {sa_active, busy, res_valid}, 3'b110);
        checkOutput("hand saA latched", sa_a, aPat0);

        #1;
        rst = 1'b1;
        #1;
        checkOutput("hand rst flags", {sa_active, busy, res_valid, sa_clr}, 4'b0000);
        checkOutput("hand rst saA", sa_a, 128'h0);

        @(posedge clk); #1;
        rst  = 1'b0;
        req1 = 1'b1;
        a0   = aPat0;
        res_ready = 1'b1;
        @(negedge clk);
        checkOutput("hand post-rst gnt1", {gnt0, gnt1}, 2'b01);

        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        checkOutput("hand post-rst clr", sa_clr, 1'b1);
        checkOutput("hand post-rst saB", sa_b, bPat1);

        n = 0;
        do begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end while (!res_valid && n < 60);
        checkOutput("hand resp latency", n, 18);
        checkOutput("hand resp", {res_valid, res_id, res_err}, 3'b110);
        checkOutput("hand resp c", res_c, 32'h0BADF00D);

        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        checkOutput("hand idle after accept", {res_valid, busy}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/sa3_job_scheduler.md
Name: sa3_job_scheduler

Overview:
Round-robin arbiter and sequencer that shares one 3x3 systolic convolution array between two requesters.
- Each job is one 4x4 input tile plus one 3x3 filter, producing a 2x2 output.
- Per job the block grants one requester, latches its operands, and pulses a clear to the array. It then holds the array's active input high until done (or a watchdog timeout) and returns the captured 2x2 result through a valid/ready handshake.
- Sits between the layer-level tile fetch logic and the array instance.

Parameters:
TIMEOUT, 32, max RUN-state cycles allowed before abort; must be >= 18.
CNT_W, 6, width of RUN cycle counter; must hold TIMEOUT-1.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
req0  input  1  requester 0 job request, level, held until gnt0
a0  input  128  requester 0 tile; aij at bits [8*(4*(i-1)+(j-1)) +: 8]
b0  input  72  requester 0 filter; bij at bits [8*(3*(i-1)+(j-1)) +: 8]
gnt0  output  1  one-cycle grant to requester 0; operands sampled this edge
req1, a1, b1, gnt1  same as above for requester 1
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_id  output  1  requester index owning result
res_c  output  32  c11[7:0], c12[15:8], c21[23:16], c22[31:24]
res_err  output  1  job aborted by timeout; res_c is 0
busy  output  1  high in any state except IDLE
sa_clr  output  1  one-cycle clear; top level ORs it into the array reset
sa_active  output  1  array active_sa3
sa_a  output  128  latched tile to array, same packing as a0
sa_b  output  72  latched filter to array
sa_done  input  1  array done pulse
sa_c  input  32  array outputs, same packing as res_c

Behaviour:
- Reset values:
  - All outputs 0; internal operand registers 0.
  - State IDLE; rr pointer 0, so requester 0 has priority first.
  - RUN counter 0.
- IDLE:
  - gnt is combinational. Requester x is granted if it is the only one requesting. If both request, rr chooses: rr=0 grants req0, rr=1 grants req1.
  - On the grant edge: latch the winner's a/b into sa_a/sa_b, latch its index into the job id register, then go to CLEAR.
  - No request: stay in IDLE.
- CLEAR:
  - sa_clr=1 and sa_active=0 for exactly one cycle; this restores the array FSM and accumulators even after an aborted job.
  - Then RUN with counter 0.
- RUN:
  - sa_active=1; counter increments every cycle.
  - sa_done=1: capture sa_c into res_c, res_err=0, go to RESP.
  - Counter reaches TIMEOUT-1 without sa_done: res_c=0, res_err=1, go to RESP.
  - sa_done on the timeout cycle counts as success.
- RESP:
  - sa_active=0, so the array does not restart.
  - res_valid=1; res_id, res_c and res_err are held stable until res_ready is seen high.
  - On the accept edge: res_valid drops, rr becomes ~res_id, go to IDLE. The next grant can appear in the following cycle.
- Latency:
  - Grant at cycle T, sa_clr at T+1, RUN from T+2.
  - A nominal 17-cycle array run gives sa_done at T+18 and res_valid at T+19.
- Requests arriving in CLEAR, RUN or RESP are not granted; gnt0/gnt1 stay 0 there. At most one gnt is high in any cycle.
- sa_a/sa_b stay constant from the grant edge until the next grant.
- Asynchronous rst in any state returns everything to reset values at once. An in-flight job is dropped with no response.

Test Plan:
- Bench uses a stub array that drives sa_done after N RUN cycles with a fixed sa_c; no array arithmetic is checked.
- Single job: req0=1, a0 = bytes 1..16, b0 = bytes 1..9, stub N=17, sa_c=32'h04030201, res_ready=1 -> gnt0 at T, sa_clr only at T+1, sa_active T+2..T+18, res_valid at T+19 with res_id=0, res_c=32'h04030201, res_err=0.
- Contention: req0 and req1 held high from reset -> grant order 0,1,0,1 over four jobs; gnt0 and gnt1 never high together.
- Backpressure: res_ready=0 for 10 cycles after res_valid -> res_valid, res_c and res_id stay stable; no new gnt until the accept edge.
- Timeout: stub never asserts sa_done, TIMEOUT=32 -> res_valid with res_err=1 and res_c=0 after 32 RUN cycles. The next job's CLEAR pulse precedes its RUN, and it completes normally.
- Reset mid-RUN: rst asserted at RUN cycle 5 -> sa_active, busy and res_valid are 0 immediately. The next req1 alone is granted at the first IDLE cycle after rst deasserts.
- Operand latch: change a0 after gnt0 while the job is in RUN -> sa_a keeps the value latched on the grant edge.
